// File: rtl/afe_ro_sram_fifo_if.sv
// Handshake bundle for afe_ro_sram_fifo: AFE write stream, readout stream, control and status.
// Optional watermark signals exist only when AFE_RO_FIFO_WATERMARK_EN is defined.
interface afe_ro_sram_fifo_if #(
  parameter int unsigned AFE_DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH     = 10
);

  // Control
  logic                      clear_i;
  logic                      cfg_ring_i;

  // AFE sample write side
  logic                      wvalid_i;
  logic                      wready_o;
  logic [AFE_DATA_WIDTH-1:0] wdata_i;

  // Readout side
  logic                      rvalid_o;
  logic                      rready_i;
  logic [AFE_DATA_WIDTH-1:0] rdata_o;

  // Status
  logic [ADDR_WIDTH:0]       fill_o;
  logic                      overflow_o;

`ifdef AFE_RO_FIFO_WATERMARK_EN
  logic [ADDR_WIDTH:0]       wmark_i;
  logic                      wmark_o;
`endif

  // FIFO side
  modport slave (
    input  clear_i,
    input  cfg_ring_i,
    input  wvalid_i,
    output wready_o,
    input  wdata_i,
    output rvalid_o,
    input  rready_i,
    output rdata_o,
    output fill_o,
`ifdef AFE_RO_FIFO_WATERMARK_EN
    input  wmark_i,
    output wmark_o,
`endif
    output overflow_o
  );

  // Producer / consumer side
  modport master (
    output clear_i,
    output cfg_ring_i,
    output wvalid_i,
    input  wready_o,
    output wdata_i,
    input  rvalid_o,
    output rready_i,
    input  rdata_o,
    input  fill_o,
`ifdef AFE_RO_FIFO_WATERMARK_EN
    output wmark_i,
    input  wmark_o,
`endif
    input  overflow_o
  );

endinterface

// File: rtl/afe_ro_sram_fifo.sv
// AFE readout FIFO / ring buffer on a single-port 32b SRAM with a 2-entry prefetch output stage.
// Writes always win the SRAM port; reads fill the prefetch stage in write-free cycles.
// Ring mode overwrites the oldest SRAM word when full and sets a sticky overflow flag.
// Optional feature: define AFE_RO_FIFO_WATERMARK_EN to add wmark_i / wmark_o.
module afe_ro_sram_fifo #(
  parameter int unsigned AFE_DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH     = 10
) (
  input logic               clk_i,
  input logic               rst_i,
  afe_ro_sram_fifo_if.slave bus
);

  localparam int unsigned       Depth    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FillFull = (ADDR_WIDTH + 1)'(Depth);
  // Bits of the 32b SRAM word that carry sample data; the rest are never written.
  localparam logic [31:0]       DataMask = 32'((64'd1 << AFE_DATA_WIDTH) - 64'd1);

  // Pointer / occupancy state
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic                  ovf_q, ovf_d;
  logic                  inflight_q, inflight_d;

  // Prefetch stage: 2 stored entries; the word returning from SRAM bypasses to the head
  logic [AFE_DATA_WIDTH-1:0] pf_mem_q [2];
  logic                      pf_wr_q, pf_wr_d;
  logic                      pf_rd_q, pf_rd_d;
  logic [1:0]                pf_cnt_q, pf_cnt_d;

  // Single-port SRAM model (sram_wrapper_32b behaviour: registered read data, active-low bwe)
  logic [31:0]           mem [Depth];
  logic [31:0]           sram_rdata_q;
  logic                  sram_req;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_bwe_n;
  logic [AFE_DATA_WIDTH-1:0] sram_out;
  logic                  unused_sram_hi;

  // Control
  logic full;
  logic wready;
  logic wr_en;
  logic rd_en;
  logic rvalid;
  logic pop;
  logic pf_pop;
  logic pf_push;
  logic [AFE_DATA_WIDTH-1:0] head;

  assign full   = (fill_q == FillFull);
  assign wready = bus.cfg_ring_i | ~full;
  // clear_i blocks both SRAM accesses in its cycle
  assign wr_en  = bus.wvalid_i & wready & ~bus.clear_i;
  assign rd_en  = ~bus.clear_i & ~wr_en & (fill_q != '0) &
                  ((pf_cnt_q + 2'(inflight_q)) < 2'd2);

  assign sram_out       = sram_rdata_q[AFE_DATA_WIDTH-1:0];
  assign unused_sram_hi = ^(sram_rdata_q & ~DataMask);

  assign rvalid  = (pf_cnt_q != 2'd0) | inflight_q;
  assign head    = (pf_cnt_q != 2'd0) ? pf_mem_q[pf_rd_q] : sram_out;
  assign pop     = rvalid & bus.rready_i;
  assign pf_pop  = pop & (pf_cnt_q != 2'd0);
  // A returning word consumed straight through the bypass is never stored
  assign pf_push = inflight_q & ~(pop & (pf_cnt_q == 2'd0));

  assign sram_req   = wr_en | rd_en;
  assign sram_we    = wr_en;
  assign sram_addr  = wr_en ? wptr_q : rptr_q;
  assign sram_wdata = 32'(bus.wdata_i);
  assign sram_bwe_n = ~DataMask;

  assign bus.wready_o   = wready;
  assign bus.rvalid_o   = rvalid;
  assign bus.rdata_o    = rvalid ? head : '0;
  assign bus.fill_o     = fill_q;
  assign bus.overflow_o = ovf_q;

  // Next-state for pointers, occupancy, overflow flag and prefetch bookkeeping
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fill_d     = fill_q;
    ovf_d      = ovf_q;
    inflight_d = rd_en;
    pf_wr_d    = pf_wr_q;
    pf_rd_d    = pf_rd_q;
    pf_cnt_d   = pf_cnt_q;
    if (bus.clear_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      fill_d     = '0;
      ovf_d      = 1'b0;
      inflight_d = 1'b0;
      pf_wr_d    = 1'b0;
      pf_rd_d    = 1'b0;
      pf_cnt_d   = 2'd0;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + ADDR_WIDTH'(1);
        if (full) begin
          // Ring overwrite: the oldest SRAM word is dropped, occupancy unchanged
          rptr_d = rptr_q + ADDR_WIDTH'(1);
          ovf_d  = 1'b1;
        end else begin
          fill_d = fill_q + (ADDR_WIDTH + 1)'(1);
        end
      end else if (rd_en) begin
        rptr_d = rptr_q + ADDR_WIDTH'(1);
        fill_d = fill_q - (ADDR_WIDTH + 1)'(1);
      end
      if (pf_push) begin
        pf_wr_d = ~pf_wr_q;
      end
      if (pf_pop) begin
        pf_rd_d = ~pf_rd_q;
      end
      pf_cnt_d = pf_cnt_q + 2'(pf_push) - 2'(pf_pop);
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      fill_q      <= '0;
      ovf_q       <= 1'b0;
      inflight_q  <= 1'b0;
      pf_wr_q     <= 1'b0;
      pf_rd_q     <= 1'b0;
      pf_cnt_q    <= 2'd0;
      pf_mem_q[0] <= '0;
      pf_mem_q[1] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fill_q     <= fill_d;
      ovf_q      <= ovf_d;
      inflight_q <= inflight_d;
      pf_wr_q    <= pf_wr_d;
      pf_rd_q    <= pf_rd_d;
      pf_cnt_q   <= pf_cnt_d;
      if (pf_push && !bus.clear_i) begin
        pf_mem_q[pf_wr_q] <= sram_out;
      end
    end
  end

  // SRAM array: bit-masked write, registered read; contents are not reset
  always_ff @(posedge clk_i) begin
    if (sram_req && sram_we) begin
      mem[sram_addr] <= (mem[sram_addr] & sram_bwe_n) | (sram_wdata & ~sram_bwe_n);
    end
    if (sram_req && !sram_we) begin
      sram_rdata_q <= mem[sram_addr];
    end
  end

`ifdef AFE_RO_FIFO_WATERMARK_EN
  logic wmark_q, wmark_d;

  // Watermark tracks the occupancy that will be visible next cycle
  always_comb begin
    wmark_d = (fill_d >= bus.wmark_i) & (bus.wmark_i != '0);
    if (bus.clear_i) begin
      wmark_d = 1'b0;
    end
  end

  // Registered watermark flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wmark_q <= 1'b0;
    end else begin
      wmark_q <= wmark_d;
    end
  end

  assign bus.wmark_o = wmark_q;
`endif

endmodule

// File: tb/tb_afe_ro_sram_fifo.sv
// Directed bench for afe_ro_sram_fifo (ADDR_WIDTH=4, 12-bit samples).
// Inputs are driven on the falling edge; outputs are sampled 1 ns later, before the rising edge.
module tb_afe_ro_sram_fifo;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 12;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  afe_ro_sram_fifo_if #(.AFE_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  afe_ro_sram_fifo #(
    .AFE_DATA_WIDTH(DW),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          clr;
    logic          e_wready;
    logic          e_rvalid;
    logic [DW-1:0] e_rdata;
    logic [AW:0]   e_fill;
    logic          e_ovf;
  } vec_t;

  vec_t        vecs [23];
  int unsigned exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rr,
                       input logic clr, input logic ring);
    @(negedge clk);
    bus.wvalid_i   = wv;
    bus.wdata_i    = wd;
    bus.rready_i   = rr;
    bus.clear_i    = clr;
    bus.cfg_ring_i = ring;
    #1;
  endtask

  // Reads with rready=1 until exp_q is consumed (bounded), then expects an empty FIFO.
  task automatic drain(input string name, input logic ring);
    int idx = 0;
    for (int c = 0; c < 64 && idx < exp_q.size(); c++) begin
      drive(1'b0, '0, 1'b1, 1'b0, ring);
      if (bus.rvalid_o) begin
        check($sformatf("%s word%0d", name, idx), 32'(bus.rdata_o), exp_q[idx]);
        idx++;
      end
    end
    check({name, " count"}, 32'(idx), exp_q.size());
    drive(1'b0, '0, 1'b1, 1'b0, ring);
    check({name, " rvalid end"}, 32'(bus.rvalid_o), 0);
    check({name, " fill end"}, 32'(bus.fill_o), 0);
  endtask

  initial begin
    // wv, wd, rr, clr | wready, rvalid, rdata, fill, ovf
    vecs[0]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
    vecs[1]  = '{1'b1, 12'h0A5, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
    vecs[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd1, 1'b0};
    vecs[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0A5, 5'd0, 1'b0};
    vecs[4]  = '{1'b1, 12'h03C, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0A5, 5'd0, 1'b0};
    vecs[5]  = '{1'b1, 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0A5, 5'd1, 1'b0};
    vecs[6]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0A5, 5'd2, 1'b0};
    vecs[7]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0A5, 5'd1, 1'b0};
    vecs[8]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0A5, 5'd1, 1'b0};
    vecs[9]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0A5, 5'd1, 1'b0};
    vecs[10] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h03C, 5'd1, 1'b0};
    vecs[11] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h03C, 5'd0, 1'b0};
    vecs[12] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF, 5'd0, 1'b0};
    vecs[13] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
    vecs[14] = '{1'b1, 12'h123, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
    vecs[15] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 5'd1, 1'b0};
    vecs[16] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h123, 5'd0, 1'b0};
    vecs[17] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
    vecs[18] = '{1'b1, 12'h456, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
    vecs[19] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd1, 1'b0};
    vecs[20] = '{1'b1, 12'h789, 1'b0, 1'b1, 1'b1, 1'b1, 12'h456, 5'd0, 1'b0};
    vecs[21] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};
    vecs[22] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 5'd0, 1'b0};

    rst            = 1'b1;
    bus.wvalid_i   = 1'b0;
    bus.wdata_i    = '0;
    bus.rready_i   = 1'b0;
    bus.clear_i    = 1'b0;
    bus.cfg_ring_i = 1'b0;
`ifdef AFE_RO_FIFO_WATERMARK_EN
    bus.wmark_i    = 5'd4;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef AFE_RO_FIFO_WATERMARK_EN
    #1 check("reset wmark", 32'(bus.wmark_o), 0);
`endif

    // Table: reset state, first-word latency, prefetch fill/bypass, clear with read in flight
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].clr, 1'b0);
      check($sformatf("v%0d wready", i), 32'(bus.wready_o), 32'(vecs[i].e_wready));
      check($sformatf("v%0d rvalid", i), 32'(bus.rvalid_o), 32'(vecs[i].e_rvalid));
      check($sformatf("v%0d rdata", i), 32'(bus.rdata_o), 32'(vecs[i].e_rdata));
      check($sformatf("v%0d fill", i), 32'(bus.fill_o), 32'(vecs[i].e_fill));
      check($sformatf("v%0d overflow", i), 32'(bus.overflow_o), 32'(vecs[i].e_ovf));
    end

    // FIFO mode: 16 back-to-back writes fill the SRAM, then backpressure
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      check($sformatf("A wready w%0d", i), 32'(bus.wready_o), 1);
    end
    drive(1'b1, 12'h099, 1'b0, 1'b0, 1'b0);
    check("A wready full", 32'(bus.wready_o), 0);
    check("A fill full", 32'(bus.fill_o), 16);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("A fill after 1st read", 32'(bus.fill_o), 15);
    check("A rdata head", 32'(bus.rdata_o), 0);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("A fill settled", 32'(bus.fill_o), 14);
    check("A wready settled", 32'(bus.wready_o), 1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    drain("A drain", 1'b0);

    // Ring mode: 0,1 prefetched, then 18 writes overwrite the two oldest SRAM words (2,3)
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 12'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 12'd1, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i < 20; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
      if (i == 18) begin
        check("B fill at first overwrite", 32'(bus.fill_o), 16);
        check("B wready when full in ring", 32'(bus.wready_o), 1);
        check("B overflow before overwrite", 32'(bus.overflow_o), 0);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("B overflow set", 32'(bus.overflow_o), 1);
    check("B fill stays full", 32'(bus.fill_o), 16);
    check("B wready after ring->fifo", 32'(bus.wready_o), 0);
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(1);
    for (int i = 4; i < 20; i++) exp_q.push_back(i);
    drain("B drain", 1'b0);
    check("B overflow sticky", 32'(bus.overflow_o), 1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("B overflow cleared", 32'(bus.overflow_o), 0);

    // Simultaneous writes every cycle with rready=1: reads stall until writes stop
    begin
      int idx = 0;
      exp_q.delete();
      for (int i = 0; i < 10; i++) exp_q.push_back(100 + i);
      for (int c = 0; c < 40 && idx < 10; c++) begin
        drive(c < 10, DW'(100 + c), 1'b1, 1'b0, 1'b0);
        if (c == 9) check("C rvalid stalled", 32'(bus.rvalid_o), 0);
        if (bus.rvalid_o) begin
          check($sformatf("C word%0d", idx), 32'(bus.rdata_o), exp_q[idx]);
          idx++;
        end
      end
      check("C count", 32'(idx), 10);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("C rvalid end", 32'(bus.rvalid_o), 0);
    end

    // Clear with 5 words stored and a read in flight
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, DW'(200 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 12'h777, 1'b0, 1'b1, 1'b0);
    check("D fill before clear", 32'(bus.fill_o), 5);
    check("D rvalid before clear", 32'(bus.rvalid_o), 1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("D fill after clear", 32'(bus.fill_o), 0);
    check("D rvalid after clear", 32'(bus.rvalid_o), 0);
    check("D rdata after clear", 32'(bus.rdata_o), 0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("D no stale word", 32'(bus.rvalid_o), 0);
    drive(1'b1, 12'h300, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    exp_q.push_back(12'h300);
    drain("D drain", 1'b0);

`ifdef AFE_RO_FIFO_WATERMARK_EN
    // Watermark 4: two words prefetched, rises after the 6th write, falls as fill drops to 3
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      repeat (2) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 2; i < 6; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      check($sformatf("W wmark low w%0d", i), 32'(bus.wmark_o), 0);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("W wmark high", 32'(bus.wmark_o), 1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("W wmark still high", 32'(bus.wmark_o), 1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("W wmark falls", 32'(bus.wmark_o), 0);
    exp_q.delete();
    for (int i = 2; i < 6; i++) exp_q.push_back(i);
    drain("W drain", 1'b0);
`endif

    // Asynchronous reset mid-operation
    drive(1'b1, 12'h055, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 12'h066, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("E rvalid before reset", 32'(bus.rvalid_o), 1);
    #2 rst = 1'b1;
    #1;
    check("E fill in reset", 32'(bus.fill_o), 0);
    check("E rvalid in reset", 32'(bus.rvalid_o), 0);
    check("E wready in reset", 32'(bus.wready_o), 1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("E rvalid after reset", 32'(bus.rvalid_o), 0);
    check("E fill after reset", 32'(bus.fill_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
